gon_multicast_scheduler: RTL and testbench

Sequencer for one GON X multicast bus row. It first loads the ID scan chain of the row's NUM_NODES multicast controllers. It then queues (tag, value) multicast requests and drives them onto the shared row bus one at a time, completing each beat on the bus ready handshake. It sits between the global buffer / top-level control and the row of per-PE multicast controllers.

---
 rtl/gon_multicast_scheduler.sv | 173 +++++++++++++++++
 tb/tb_gon_multicast_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gon_multicast_scheduler.sv
// ---------------------------------------------------------------------------
// gon_multicast_scheduler
//
// Sequencer for one GON X multicast bus row. It first loads the ID scan chain
// of the row's NUM_NODES multicast controllers. It then queues (tag, value)
// requests and drives them onto the shared row bus one beat at a time.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   cfg_start            request an ID-chain load
//   cfg_valid, cfg_id    next ID to shift into the chain
//   set_id, id_chain_out registered shift enable / ID into the chain head
//   cfg_done             one-cycle pulse with the last set_id of a load
//   req_valid/ready      request handshake (req_tag, req_value)
//   bus_tag/value/enable beat broadcast to the row, completed on bus_ready
//   busy                 loading the chain, or running with queued requests
// ---------------------------------------------------------------------------
module gon_multicast_scheduler #(
    parameter int ID_LEN     = 4,
    parameter int VALUE_LEN  = 32,
    parameter int NUM_NODES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic [ID_LEN-1:0]    cfg_id,
    output logic                 set_id,
    output logic [ID_LEN-1:0]    id_chain_out,
    output logic                 cfg_done,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ID_LEN-1:0]    req_tag,
    input  logic [VALUE_LEN-1:0] req_value,
    output logic [ID_LEN-1:0]    bus_tag,
    output logic                 bus_enable,
    output logic [VALUE_LEN-1:0] bus_value,
    input  logic                 bus_ready,
    output logic                 busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_NODES + 1);
    localparam int EW = ID_LEN + VALUE_LEN;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONFIG = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              set_id_q, set_id_d;
    logic [ID_LEN-1:0] id_q, id_d;
    logic              cfg_done_q, cfg_done_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic          fifo_empty;
    logic          fifo_full;
    logic          in_run;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign in_run     = (state_q == ST_RUN);
    // Acceptance depends only on registered state, so no path from req_valid
    // or bus_ready reaches req_ready.
    assign push       = in_run & req_valid & ~fifo_full;
    // The queue can only hold entries while running, so a non-empty queue
    // alone qualifies the beat.
    assign pop        = ~fifo_empty & bus_ready;
    assign head       = mem_q[rd_ptr_q];

    // Payload storage carries no reset: stale entries are never visible
    // because the head is masked whenever the occupancy count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_tag, req_value};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        set_id_d   = 1'b0;
        id_d       = id_q;
        cfg_done_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_CONFIG;
                    cnt_d   = '0;
                end
            end
            ST_CONFIG: begin
                if (cfg_valid) begin
                    set_id_d = 1'b1;
                    id_d     = cfg_id;
                    cnt_d    = cnt_q + CW'(1);
                    // cfg_done is registered alongside the final set_id.
                    if (cnt_q == CW'(NUM_NODES - 1)) begin
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Reload only from a quiescent queue; otherwise the request
                // is dropped rather than remembered.
                if (cfg_start && fifo_empty && !push) begin
                    state_d = ST_CONFIG;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            set_id_q   <= 1'b0;
            id_q       <= '0;
            cfg_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_id_q   <= set_id_d;
            id_q       <= id_d;
            cfg_done_q <= cfg_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign set_id       = set_id_q;
    assign id_chain_out = id_q;
    assign cfg_done     = cfg_done_q;
    assign req_ready    = in_run & ~fifo_full;
    assign bus_enable   = ~fifo_empty;
    assign bus_tag      = fifo_empty ? '0 : head[EW-1:VALUE_LEN];
    assign bus_value    = fifo_empty ? '0 : head[VALUE_LEN-1:0];
    assign busy         = (state_q == ST_CONFIG) | (in_run & ~fifo_empty);

endmodule

// File: tb/tb_gon_multicast_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gon_multicast_scheduler
//
// Cycle-level bench: a small behavioural model tracks the controller state,
// the expected chain outputs and a scoreboard queue of accepted requests.
// Every cycle the DUT outputs are compared with the model; each completed
// bus beat pops the scoreboard and compares tag and value.
// ---------------------------------------------------------------------------
module tb_gon_multicast_scheduler;

    localparam int ID_LEN     = 4;
    localparam int VALUE_LEN  = 32;
    localparam int NUM_NODES  = 8;
    localparam int FIFO_DEPTH = 4;

    localparam int M_IDLE   = 0;
    localparam int M_CONFIG = 1;
    localparam int M_RUN    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cfg_start = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic [ID_LEN-1:0]    cfg_id = '0;
    logic                 set_id;
    logic [ID_LEN-1:0]    id_chain_out;
    logic                 cfg_done;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [ID_LEN-1:0]    req_tag = '0;
    logic [VALUE_LEN-1:0] req_value = '0;
    logic [ID_LEN-1:0]    bus_tag;
    logic                 bus_enable;
    logic [VALUE_LEN-1:0] bus_value;
    logic                 bus_ready = 1'b0;
    logic                 busy;

    gon_multicast_scheduler #(
        .ID_LEN     (ID_LEN),
        .VALUE_LEN  (VALUE_LEN),
        .NUM_NODES  (NUM_NODES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_id       (cfg_id),
        .set_id       (set_id),
        .id_chain_out (id_chain_out),
        .cfg_done     (cfg_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_tag      (req_tag),
        .req_value    (req_value),
        .bus_tag      (bus_tag),
        .bus_enable   (bus_enable),
        .bus_value    (bus_value),
        .bus_ready    (bus_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int                              m_state = M_IDLE;
    int                              m_cnt   = 0;
    logic                            m_set   = 1'b0;
    logic [ID_LEN-1:0]               m_id    = '0;
    logic                            m_done  = 1'b0;
    logic                            m_pushed = 1'b0;
    logic [ID_LEN+VALUE_LEN-1:0]     sb [$];
    int                              set_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs with the model, then advance model and DUT by one
    // clock. Called at posedge+1 with the cycle's inputs already applied.
    task automatic tick();
        logic do_push;
        logic do_pop;
        logic [ID_LEN+VALUE_LEN-1:0] front;

        check_eq("set_id",       set_id,       m_set);
        check_eq("id_chain_out", id_chain_out, m_id);
        check_eq("cfg_done",     cfg_done,     m_done);
        check_eq("req_ready",    req_ready,
                 (m_state == M_RUN) && (sb.size() < FIFO_DEPTH));
        check_eq("busy",         busy,
                 (m_state == M_CONFIG) || ((m_state == M_RUN) && (sb.size() != 0)));
        check_eq("bus_enable",   bus_enable,   sb.size() != 0);
        if (sb.size() == 0) begin
            check_eq("bus_tag_idle",   bus_tag,   0);
            check_eq("bus_value_idle", bus_value, 0);
        end
        if (set_id === 1'b1) set_seen++;

        do_push  = (m_state == M_RUN) && req_valid && (sb.size() < FIFO_DEPTH);
        do_pop   = (sb.size() != 0) && bus_ready;
        m_pushed = 1'b0;
        m_set    = 1'b0;
        m_done   = 1'b0;

        if (!rst) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_id    = '0;
            sb.delete();
        end else begin
            if (do_pop) begin
                front = sb.pop_front();
                check_eq("beat_tag",   bus_tag,   front[ID_LEN+VALUE_LEN-1:VALUE_LEN]);
                check_eq("beat_value", bus_value, front[VALUE_LEN-1:0]);
                $display("beat tag=%0h value=%0h", bus_tag, bus_value);
            end
            case (m_state)
                M_IDLE: begin
                    if (cfg_start) begin
                        m_state = M_CONFIG;
                        m_cnt   = 0;
                    end
                end
                M_CONFIG: begin
                    if (cfg_valid) begin
                        m_set = 1'b1;
                        m_id  = cfg_id;
                        m_cnt++;
                        $display("cfg id=%0h count=%0d", cfg_id, m_cnt);
                        if (m_cnt == NUM_NODES) begin
                            m_state = M_RUN;
                            m_done  = 1'b1;
                        end
                    end
                end
                default: begin
                    // do_pop was taken above, so re-derive emptiness from
                    // the pre-pop occupancy.
                    if (cfg_start && !do_push && (sb.size() + (do_pop ? 1 : 0)) == 0) begin
                        m_state = M_CONFIG;
                        m_cnt   = 0;
                    end
                end
            endcase
            if (do_push) begin
                sb.push_back({req_tag, req_value});
                m_pushed = 1'b1;
                $display("push tag=%0h value=%0h", req_tag, req_value);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_chain(input int stall_after, input int stall_len, input logic descending);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (i == stall_after) begin
                cfg_valid = 1'b0;
                repeat (stall_len) tick();
            end
            cfg_valid = 1'b1;
            cfg_id    = descending ? ID_LEN'(NUM_NODES - 1 - i) : ID_LEN'($urandom);
            tick();
        end
        cfg_valid = 1'b0;
        tick();
    endtask

    task automatic push_req(input logic [ID_LEN-1:0] tag, input logic [VALUE_LEN-1:0] val);
        req_valid = 1'b1;
        req_tag   = tag;
        req_value = val;
        for (int w = 0; w < 10; w++) begin
            tick();
            if (m_pushed) break;
        end
        check_eq("push_accepted", m_pushed, 1'b1);
        req_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Chain load 7..0, continuous
        set_seen = 0;
        load_chain(NUM_NODES, 0, 1'b1);
        check_eq("set_id_cycles", set_seen, NUM_NODES);

        // Back-to-back multicast
        bus_ready = 1'b1;
        req_valid = 1'b1;
        req_tag = 4'd1; req_value = 32'hA; tick();
        req_tag = 4'd2; req_value = 32'hB; tick();
        req_tag = 4'd3; req_value = 32'hC; tick();
        req_valid = 1'b0;
        repeat (4) tick();

        // Backpressure and full; fifth request held until space frees
        bus_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_req(ID_LEN'(k + 4), $urandom);
        req_valid = 1'b1;
        req_tag   = 4'd9;
        req_value = $urandom;
        repeat (2) tick();
        check_eq("full_no_push", m_pushed, 1'b0);
        bus_ready = 1'b1;
        push_req(4'd9, req_value);
        repeat (6) tick();
        check_eq("drained", bus_enable, 1'b0);

        // Reconfigure ignored with 2 queued entries
        bus_ready = 1'b0;
        push_req(4'd10, $urandom);
        push_req(4'd11, $urandom);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        check_eq("reconfig_ignored_ready", req_ready, 1'b1);
        bus_ready = 1'b1;
        repeat (3) tick();
        bus_ready = 1'b0;
        // Reconfigure from empty, with a 3-cycle stall after 4 IDs
        set_seen = 0;
        load_chain(4, 3, 1'b0);
        check_eq("set_id_cycles_stall", set_seen, NUM_NODES);

        // Reset during CONFIG after 3 IDs
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_id = ID_LEN'(i);
            tick();
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        load_chain(NUM_NODES, 0, 1'b0);

        // Reset during RUN with 3 queued entries
        push_req(4'd12, $urandom);
        push_req(4'd13, $urandom);
        push_req(4'd14, $urandom);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        load_chain(NUM_NODES, 0, 1'b1);
        bus_ready = 1'b1;
        repeat (4) tick();
        check_eq("no_reemit", bus_enable, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
